// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU MAR/MDR bus control and mem_responder.
// The master drives the request fields, and the slave returns read data, a completion pulse and a busy flag.
interface mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              Req;
    logic              WE;
    logic [ADDR_W-1:0] Addr;
    logic [15:0]       Data_in;
    logic [15:0]       Data_out;
    logic              Ready;
    logic              Busy;

    modport master (
        output Req,
        output WE,
        output Addr,
        output Data_in,
        input  Data_out,
        input  Ready,
        input  Busy
    );

    modport slave (
        input  Req,
        input  WE,
        input  Addr,
        input  Data_in,
        output Data_out,
        output Ready,
        output Busy
    );
endinterface

// File: rtl/mem_responder.sv
// Single-request word memory responder: Ready pulses WAIT_STATES+1 cycles after Req is sampled in IDLE.
// No queueing: requests presented while Busy are dropped, so the initiator holds Req until it sees Ready.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              we_q, we_d;
    logic [15:0]       d_q, d_d;
    logic [15:0]       dout_q;

    logic              commit;
    logic [ADDR_W-1:0] c_a;
    logic              c_we;
    logic [15:0]       c_d;

    logic [15:0]       mem_q [2**ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        we_d    = we_q;
        d_d     = d_q;
        commit  = 1'b0;
        c_a     = a_q;
        c_we    = we_q;
        c_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Req) begin
                    a_d  = bus.Addr;
                    we_d = bus.WE;
                    d_d  = bus.Data_in;
                    // Zero wait states commit straight from the bus on the sample edge.
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        c_a     = bus.Addr;
                        c_we    = bus.WE;
                        c_d     = bus.Data_in;
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            we_q    <= 1'b0;
            d_q     <= 16'h0000;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            we_q    <= we_d;
            d_q     <= d_d;
            if (commit && !c_we) begin
                dout_q <= mem_q[c_a];
            end
        end
    end

    // The array has no reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge Clk) begin
        if (!Reset && commit && c_we) begin
            mem_q[c_a] <= c_d;
        end
    end

    assign bus.Ready    = (state_q == S_ACK);
    assign bus.Busy     = (state_q != S_IDLE);
    assign bus.Data_out = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 instance driven from a vector table and corner sequences,
// plus a WAIT_STATES=0 instance for the zero-wait latency case.
module tb_mem_responder;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    mem_responder_if #(.ADDR_W(8)) bus  ();
    mem_responder_if #(.ADDR_W(8)) bus0 ();

    mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ticks until Ready is seen or the budget runs out; n counts the ticks taken.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.Ready && n < 20) begin
            tick();
            n = n + 1;
        end
    endtask

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [15:0] din,
                          input logic [15:0] exp_dout, input string name);
        int n;
        bus.Req     = 1'b1;
        bus.WE      = we;
        bus.Addr    = addr;
        bus.Data_in = din;
        tick();
        bus.Req = 1'b0;
        check({name, " busy"}, {31'd0, bus.Busy}, 32'd1);
        wait_ready(n);
        check({name, " latency"}, n + 1, 32'd3);
        check({name, " dout"}, {16'd0, bus.Data_out}, {16'd0, exp_dout});
        tick();
        check({name, " ready drop"}, {31'd0, bus.Ready}, 32'd0);
    endtask

    initial begin
        int n;
        int last_rdy;
        int nr;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{we: 1'b1, addr: 8'h3A, din: 16'hBEEF, exp_dout: 16'h0000};
        vecs[1] = '{we: 1'b1, addr: 8'h00, din: 16'h0000, exp_dout: 16'h0000};
        vecs[2] = '{we: 1'b1, addr: 8'h01, din: 16'h1234, exp_dout: 16'h0000};
        vecs[3] = '{we: 1'b1, addr: 8'h20, din: 16'h0000, exp_dout: 16'h0000};
        vecs[4] = '{we: 1'b1, addr: 8'h10, din: 16'h5555, exp_dout: 16'h0000};
        vecs[5] = '{we: 1'b0, addr: 8'h3A, din: 16'h0000, exp_dout: 16'hBEEF};
        vecs[6] = '{we: 1'b0, addr: 8'h00, din: 16'hFFFF, exp_dout: 16'h0000};
        vecs[7] = '{we: 1'b0, addr: 8'h01, din: 16'h0000, exp_dout: 16'h1234};
        vecs[8] = '{we: 1'b1, addr: 8'h3A, din: 16'hC0DE, exp_dout: 16'h1234};
        vecs[9] = '{we: 1'b0, addr: 8'h3A, din: 16'h0000, exp_dout: 16'hC0DE};

        // Reset held for two cycles with a request pending on both instances.
        rst          = 1'b1;
        bus.Req      = 1'b1;
        bus.WE       = 1'b1;
        bus.Addr     = 8'h3A;
        bus.Data_in  = 16'h1111;
        bus0.Req     = 1'b1;
        bus0.WE      = 1'b1;
        bus0.Addr    = 8'hFF;
        bus0.Data_in = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset ready", {31'd0, bus.Ready}, 32'd0);
            check("reset busy", {31'd0, bus.Busy}, 32'd0);
            check("reset dout", {16'd0, bus.Data_out}, 32'd0);
            check("reset busy ws0", {31'd0, bus0.Busy}, 32'd0);
        end
        rst      = 1'b0;
        bus.Req  = 1'b0;
        bus0.Req = 1'b0;
        tick();
        check("idle after reset", {31'd0, bus.Busy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp_dout, $sformatf("vec%0d", i));
        end

        // Held Req alternating 0x00 / 0x01: Ready every 4 cycles.
        bus.Req  = 1'b1;
        bus.WE   = 1'b0;
        bus.Addr = 8'h00;
        last_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ready(n);
            check("held ready seen", {31'd0, bus.Ready}, 32'd1);
            check("held dout", {16'd0, bus.Data_out}, (i % 2 == 0) ? 32'h0 : 32'h1234);
            if (i > 0) check("held period", cyc - last_rdy, 32'd4);
            last_rdy = cyc;
            bus.Addr = (i % 2 == 0) ? 8'h01 : 8'h00;
            tick();
            check("held ready pulse", {31'd0, bus.Ready}, 32'd0);
        end
        bus.Req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("held quiesce", {31'd0, bus.Busy}, 32'd0);

        // Write to 0x10 presented during the WAIT of a read is dropped.
        bus.Req  = 1'b1;
        bus.WE   = 1'b0;
        bus.Addr = 8'h10;
        tick();
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                bus.Req     = 1'b1;
                bus.WE      = 1'b1;
                bus.Data_in = 16'hFFFF;
            end
            if (i == 2) bus.Req = 1'b0;
            if (bus.Ready) begin
                nr = nr + 1;
                check("drop read dout", {16'd0, bus.Data_out}, 32'h5555);
            end
            tick();
        end
        check("drop ready count", nr, 32'd1);
        do_req(1'b0, 8'h10, 16'h0000, 16'h5555, "drop readback");

        // Reset in the first WAIT cycle of a write abandons it.
        do_req(1'b0, 8'h01, 16'h0000, 16'h1234, "pre rst read");
        bus.Req     = 1'b1;
        bus.WE      = 1'b1;
        bus.Addr    = 8'h20;
        bus.Data_in = 16'hAAAA;
        tick();
        bus.Req = 1'b0;
        check("midwr busy", {31'd0, bus.Busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midwr busy cleared", {31'd0, bus.Busy}, 32'd0);
        check("midwr dout cleared", {16'd0, bus.Data_out}, 32'd0);
        nr = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.Ready) nr = nr + 1;
            tick();
        end
        check("midwr no ready", nr, 32'd0);
        do_req(1'b0, 8'h20, 16'h0000, 16'h0000, "midwr readback");

        // Reset during ACK keeps the committed write but clears Data_out.
        do_req(1'b0, 8'h3A, 16'h0000, 16'hC0DE, "pre ack read");
        bus.Req     = 1'b1;
        bus.WE      = 1'b1;
        bus.Addr    = 8'h40;
        bus.Data_in = 16'h7777;
        tick();
        bus.Req = 1'b0;
        wait_ready(n);
        check("ackrst ready", {31'd0, bus.Ready}, 32'd1);
        check("ackrst dout held", {16'd0, bus.Data_out}, 32'hC0DE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ackrst dout cleared", {16'd0, bus.Data_out}, 32'd0);
        do_req(1'b0, 8'h40, 16'h0000, 16'h7777, "ackrst readback");

        // Zero wait states: Ready one cycle after the sample edge, Busy for one cycle.
        bus0.Req     = 1'b1;
        bus0.WE      = 1'b1;
        bus0.Addr    = 8'hFF;
        bus0.Data_in = 16'h0001;
        tick();
        bus0.Req = 1'b0;
        check("ws0 wr ready", {31'd0, bus0.Ready}, 32'd1);
        check("ws0 wr busy", {31'd0, bus0.Busy}, 32'd1);
        check("ws0 wr dout", {16'd0, bus0.Data_out}, 32'd0);
        tick();
        check("ws0 wr idle", {30'd0, bus0.Busy, bus0.Ready}, 32'd0);
        bus0.Req = 1'b1;
        bus0.WE  = 1'b0;
        tick();
        bus0.Req = 1'b0;
        check("ws0 rd ready", {31'd0, bus0.Ready}, 32'd1);
        check("ws0 rd busy", {31'd0, bus0.Busy}, 32'd1);
        check("ws0 rd dout", {16'd0, bus0.Data_out}, 32'h0001);
        tick();
        check("ws0 rd idle", {30'd0, bus0.Busy, bus0.Ready}, 32'd0);
        check("ws0 dout hold", {16'd0, bus0.Data_out}, 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
